mont_exp_core: RTL and testbench
================================

Name: mont_exp_core

Overview:
- Parametrised modular exponentiation engine: computes a^d mod n for WIDTH-bit operands using Montgomery multiplication.
- Successor to the fixed 256-bit RSA core. Adds a WIDTH parameter, a run-time exponent length, a busy/error handshake and a synchronous active-low reset.
- Sits under the RSA wrapper. The wrapper loads operands, pulses i_start, and collects the result on o_finished.

Parameters:
- WIDTH, 256, operand/modulus/exponent width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, width of the exponent-length input and internal counters.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_start  in  1  start request; sampled only in IDLE.
- i_a  in  WIDTH  base; must be < n.
- i_d  in  WIDTH  exponent; LSB processed first.
- i_n  in  WIDTH  modulus; must be odd.
- i_d_len  in  CNT_W  exponent bits to process, L. 0 or >WIDTH means WIDTH.
- o_busy  out  1  high from the cycle after start acceptance until o_finished.
- o_a_pow_d  out  WIDTH  result; registered, held until the next accepted start.
- o_finished  out  1  one-cycle done pulse.
- o_error  out  1  valid with o_finished; 1 means the request was rejected.

Behaviour:
- Reset: i_rst_n low at a rising edge → state IDLE and all outputs 0 after that edge. All internal registers are cleared. Reset mid-operation aborts with no o_finished pulse.
- Start:
  - i_start in IDLE latches a, d, n and L.
  - i_start outside IDLE is ignored and has no effect on the running job.
- FSM: IDLE → PREP → MUL ↔ UPD → DONE → IDLE. ERR path: IDLE → ERR → IDLE.
- Error check: if i_n[0]==0 at start, go to ERR. ERR lasts 1 cycle with o_finished=1, o_error=1, o_a_pow_d=0.
- PREP (WIDTH+1 cycles):
  - Computes t = a*2^WIDTH mod n by a shift-add-reduce loop.
  - Each cycle applies one conditional subtract of n.
  - Internal width is WIDTH+2.
  - Initialises m = 1.
- MUL (WIDTH cycles):
  - Two Montgomery multipliers run in parallel.
  - P = Mont(t,t) always.
  - Q = Mont(m,t) only when the current exponent bit is 1.
  - Each iteration: acc += x_bit ? y : 0; if acc odd, acc += n; acc >>= 1.
  - Accumulators are WIDTH+2 bits; no overflow is permitted.
- UPD (1 cycle):
  - Each product gets one conditional subtract (>=n → -n).
  - t ← P; m ← Q if the bit was 1, else m is unchanged.
  - d ← d>>1; bit counter +1.
  - If counter == L, go to DONE; else go to MUL.
- DONE (1 cycle):
  - o_a_pow_d ← (m>=n) ? m-n : m. This makes n=1 return 0.
  - o_finished=1, o_error=0, o_busy=0.
- Latency: taking the cycle after the accepting edge as cycle 1, o_finished is high in cycle (WIDTH+1) + L*(WIDTH+1) + 1.
- Back-to-back: a new start is accepted in the cycle after o_finished.
- Operand stability: i_a, i_d, i_n, i_d_len may change freely after acceptance.
- Results are undefined if a >= n, but the block must still terminate with the standard latency.

Optional Feature:
- Macro MONT_EXP_EARLY_EXIT_EN.
- When defined: in UPD, if the shifted remaining exponent (within the L-bit window) is zero, go straight to DONE. Latency becomes (WIDTH+1) + k*(WIDTH+1) + 1, where k = max(1, index of highest set bit within L + 1). With d=0, k=1.
- When undefined: exactly L bit iterations are always performed. No extra logic.

Test Plan:
- WIDTH=8, a=5, d=3, L=2, n=13 → o_a_pow_d=8, o_error=0. With macro off, o_finished at cycle 28 exactly.
- WIDTH=256, a=2, d=10, L=0 (means 256), n=1000003 → o_a_pow_d=1024. With macro off, latency 257+256*257+1 cycles.
- WIDTH=8, d=0, n=1 → o_a_pow_d=0; separately n=13 → o_a_pow_d=1. Covers the final-reduction boundary.
- WIDTH=8, n=12 (even) → o_finished and o_error=1 in cycle 1, o_a_pow_d=0; o_busy never asserted.
- Start pulsed again with new operands while o_busy=1 → ignored; the first result is still correct. Reset asserted mid-MUL → outputs 0, no o_finished; a following start gives the correct result.
- MONT_EXP_EARLY_EXIT_EN defined, WIDTH=8, a=3, d=2, L=8, n=11 → result 9. o_finished at cycle 9+2*9+1=28 instead of 82.

Source files
------------

// File: rtl/mont_exp_core.sv
// mont_exp_core: WIDTH-bit modular exponentiation a^d mod n using bit-serial
// Montgomery multiplication, processing the exponent LSB first.
// Optional feature macro: MONT_EXP_EARLY_EXIT_EN (stop once the remaining
// exponent bits inside the L-bit window are all zero).
module mont_exp_core #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_n,
  input  logic [CNT_W-1:0] i_d_len,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_a_pow_d,
  output logic             o_finished,
  output logic             o_error
);

  localparam int unsigned AW = WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_MUL,
    S_UPD,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]    t_r;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] d_r;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [AW-1:0]    acc_p_r;
  logic [AW-1:0]    acc_q_r;
  logic [WIDTH-1:0] xp_r;
  logic [WIDTH-1:0] xq_r;

  logic [CNT_W-1:0] len_in;
  logic [WIDTH-1:0] d_in;
  logic [AW-1:0]    n_ext;
  logic [AW-1:0]    prep_src;
  logic [AW-1:0]    prep_val;
  logic [AW-1:0]    acc_p_nxt;
  logic [AW-1:0]    acc_q_nxt;
  logic [AW-1:0]    p_red;
  logic [AW-1:0]    q_red;
  logic [WIDTH-1:0] m_upd;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] bit_nxt;
  logic             last_bit;

  // One Montgomery iteration: add y if the multiplier bit is set, make even, halve
  function automatic logic [AW-1:0] mont_step(input logic [AW-1:0] acc,
                                              input logic          xb,
                                              input logic [AW-1:0] y,
                                              input logic [AW-1:0] n);
    logic [AW-1:0] s;
    s = acc + (xb ? y : '0);
    if (s[0]) s = s + n;
    return s >> 1;
  endfunction

  // Datapath arithmetic: request decode, prep reduction, Montgomery steps, final reductions
  always_comb begin
    len_in    = ((i_d_len == '0) || (i_d_len > CNT_W'(WIDTH))) ? CNT_W'(WIDTH) : i_d_len;
    d_in      = i_d;
`ifdef MONT_EXP_EARLY_EXIT_EN
    if (len_in != CNT_W'(WIDTH)) d_in = i_d & ((WIDTH'(1) << len_in) - WIDTH'(1));
`endif
    n_ext     = {2'b00, n_r};
    prep_src  = (cnt_r == '0) ? t_r : {t_r[AW-2:0], 1'b0};
    prep_val  = (prep_src >= n_ext) ? prep_src - n_ext : prep_src;
    acc_p_nxt = mont_step(acc_p_r, xp_r[0], t_r, n_ext);
    acc_q_nxt = mont_step(acc_q_r, xq_r[0], t_r, n_ext);
    p_red     = (acc_p_r >= n_ext) ? acc_p_r - n_ext : acc_p_r;
    q_red     = (acc_q_r >= n_ext) ? acc_q_r - n_ext : acc_q_r;
    m_upd     = d_r[0] ? q_red[WIDTH-1:0] : m_r;
    res       = (m_upd >= n_r) ? m_upd - n_r : m_upd;
    bit_nxt   = bit_cnt_r + CNT_W'(1);
    last_bit  = (bit_nxt == len_r);
`ifdef MONT_EXP_EARLY_EXIT_EN
    if ((d_r >> 1) == '0) last_bit = 1'b1;
`endif
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_start) state_nxt = i_n[0] ? S_PREP : S_ERR;
      S_PREP: if (cnt_r == CNT_W'(WIDTH)) state_nxt = S_MUL;
      S_MUL:  if (cnt_r == CNT_W'(WIDTH - 1)) state_nxt = S_UPD;
      S_UPD:  state_nxt = last_bit ? S_DONE : S_MUL;
      S_DONE: state_nxt = S_IDLE;
      S_ERR:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, Montgomery conversion, multiply iterations and per-bit update
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      t_r       <= '0;
      m_r       <= '0;
      n_r       <= '0;
      d_r       <= '0;
      len_r     <= '0;
      cnt_r     <= '0;
      bit_cnt_r <= '0;
      acc_p_r   <= '0;
      acc_q_r   <= '0;
      xp_r      <= '0;
      xq_r      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            t_r       <= {2'b00, i_a};
            n_r       <= i_n;
            d_r       <= d_in;
            len_r     <= len_in;
            m_r       <= WIDTH'(1);
            cnt_r     <= '0;
            bit_cnt_r <= '0;
          end
        end
        S_PREP: begin
          t_r <= prep_val;
          if (cnt_r == CNT_W'(WIDTH)) begin
            cnt_r   <= '0;
            xp_r    <= prep_val[WIDTH-1:0];
            xq_r    <= m_r;
            acc_p_r <= '0;
            acc_q_r <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_MUL: begin
          acc_p_r <= acc_p_nxt;
          if (d_r[0]) acc_q_r <= acc_q_nxt;
          xp_r  <= xp_r >> 1;
          xq_r  <= xq_r >> 1;
          cnt_r <= (cnt_r == CNT_W'(WIDTH - 1)) ? '0 : cnt_r + CNT_W'(1);
        end
        S_UPD: begin
          t_r       <= p_red;
          m_r       <= m_upd;
          d_r       <= d_r >> 1;
          bit_cnt_r <= bit_nxt;
          xp_r      <= p_red[WIDTH-1:0];
          xq_r      <= m_upd;
          acc_p_r   <= '0;
          acc_q_r   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Registered handshake and result outputs, aligned with the state being entered
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_busy     <= 1'b0;
      o_finished <= 1'b0;
      o_error    <= 1'b0;
      o_a_pow_d  <= '0;
    end else begin
      o_busy     <= (state_nxt == S_PREP) || (state_nxt == S_MUL) || (state_nxt == S_UPD);
      o_finished <= (state_nxt == S_DONE) || (state_nxt == S_ERR);
      o_error    <= (state_nxt == S_ERR);
      if ((state == S_IDLE) && i_start)           o_a_pow_d <= '0;
      else if ((state == S_UPD) && last_bit)      o_a_pow_d <= res;
    end
  end

endmodule

// File: tb/tb_mont_exp_core.sv
// Scoreboard bench for mont_exp_core: WIDTH=8 and WIDTH=256 instances.
module tb_mont_exp_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start8, busy8, fin8, err8;
  logic [7:0]   a8, d8, n8, res8;
  logic [3:0]   len8;
  logic         start256, busy256, fin256, err256;
  logic [255:0] a256, d256, n256, res256;
  logic [8:0]   len256;

  mont_exp_core #(.WIDTH(8), .CNT_W(4)) u8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_a(a8), .i_d(d8), .i_n(n8),
    .i_d_len(len8), .o_busy(busy8), .o_a_pow_d(res8), .o_finished(fin8), .o_error(err8));

  mont_exp_core #(.WIDTH(256), .CNT_W(9)) u256 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start256), .i_a(a256), .i_d(d256), .i_n(n256),
    .i_d_len(len256), .o_busy(busy256), .o_a_pow_d(res256), .o_finished(fin256), .o_error(err256));

  typedef struct {
    logic [255:0] res;
    logic         err;
    int           acc_cyc;
    int           lat;
  } exp_t;

  exp_t q8[$];
  exp_t q256[$];
  exp_t e8, e256;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   done8 = 0;
  int   done256 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Expected cycle of o_finished, counting the cycle after the accepting edge as 1
  function automatic int lat_model(input int w, input int l, input logic [255:0] d);
    int le, k;
    le = (l == 0 || l > w) ? w : l;
    k  = le;
`ifdef MONT_EXP_EARLY_EXIT_EN
    k = 1;
    for (int i = 0; i < le; i++) if (d[i]) k = i + 1;
`endif
    return (w + 1) + k * (w + 1) + 1;
  endfunction

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    if (fin8) begin
      if (q8.size() == 0) begin
        total++;
        $display("FAIL unexpected_finish8: actual=1 required=0");
      end else begin
        e8 = q8.pop_front();
        check("res8", 256'(res8), e8.res);
        check("err8", 256'(err8), 256'(e8.err));
        check("lat8", 256'(cyc - e8.acc_cyc + 1), 256'(e8.lat));
        done8++;
      end
    end
  end

  // Monitor for the 256-bit instance
  always @(negedge clk) begin
    if (fin256) begin
      if (q256.size() == 0) begin
        total++;
        $display("FAIL unexpected_finish256: actual=1 required=0");
      end else begin
        e256 = q256.pop_front();
        check("res256", res256, e256.res);
        check("err256", 256'(err256), 256'(e256.err));
        check("lat256", 256'(cyc - e256.acc_cyc + 1), 256'(e256.lat));
        done256++;
      end
    end
  end

  task automatic go8(input logic [7:0] a, input logic [7:0] d, input logic [7:0] n,
                     input logic [3:0] len, input logic [7:0] r, input logic err);
    exp_t e;
    @(negedge clk);
    a8 = a; d8 = d; n8 = n; len8 = len; start8 = 1'b1;
    e.res = 256'(r); e.err = err; e.acc_cyc = cyc + 1;
    e.lat = err ? 1 : lat_model(8, int'(len), 256'(d));
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); d8 = 8'($urandom); n8 = 8'($urandom); len8 = 4'($urandom);
  endtask

  task automatic wait8(input int target, input int budget);
    for (int i = 0; i < budget && done8 < target; i++) begin
      @(negedge clk); #1;
    end
    if (done8 < target) begin
      total++;
      $display("FAIL timeout8: actual=%0d required=%0d", done8, target);
      q8.delete();
      done8 = target;
    end
  endtask

  initial begin
    rst_n = 1'b0; start8 = 1'b0; start256 = 1'b0;
    a8 = '0; d8 = '0; n8 = '0; len8 = '0;
    a256 = '0; d256 = '0; n256 = '0; len256 = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy8", 256'(busy8), 256'(0));
    check("rst_fin8", 256'(fin8), 256'(0));
    check("rst_res8", 256'(res8), 256'(0));
    check("rst_fin256", 256'(fin256), 256'(0));
    rst_n = 1'b1;

    go8(8'd5, 8'd3, 8'd13, 4'd2, 8'd8, 1'b0);     wait8(1, 200);
    go8(8'd7, 8'd5, 8'd11, 4'd3, 8'd10, 1'b0);    wait8(2, 200);
    go8(8'd100, 8'd255, 8'd251, 4'd0, 8'd113, 1'b0); wait8(3, 200);
    go8(8'd0, 8'd0, 8'd1, 4'd3, 8'd0, 1'b0);      wait8(4, 200);
    go8(8'd5, 8'd0, 8'd13, 4'd3, 8'd1, 1'b0);     wait8(5, 200);
    go8(8'd3, 8'd2, 8'd11, 4'd8, 8'd9, 1'b0);     wait8(6, 200);
    go8(8'd2, 8'd9, 8'd13, 4'd15, 8'd5, 1'b0);    wait8(7, 200);

    // Even modulus: rejected immediately, never busy
    go8(8'd5, 8'd3, 8'd12, 4'd2, 8'd0, 1'b1);
    #1;
    check("err_busy8", 256'(busy8), 256'(0));
    wait8(8, 20);
    @(negedge clk); #1;
    check("err_busy8_after", 256'(busy8), 256'(0));

    // Start while busy is ignored
    go8(8'd5, 8'd3, 8'd13, 4'd2, 8'd8, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    check("busy8_running", 256'(busy8), 256'(1));
    a8 = 8'd2; d8 = 8'd1; n8 = 8'd7; len8 = 4'd1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait8(9, 200);
    repeat (40) @(negedge clk);

    // Reset in the middle of the multiply phase aborts silently
    go8(8'd7, 8'd5, 8'd11, 4'd3, 8'd10, 1'b0);
    repeat (11) @(negedge clk);
    #1;
    check("busy8_before_rst", 256'(busy8), 256'(1));
    void'(q8.pop_back());
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("rst_mid_busy8", 256'(busy8), 256'(0));
    check("rst_mid_fin8", 256'(fin8), 256'(0));
    check("rst_mid_err8", 256'(err8), 256'(0));
    check("rst_mid_res8", 256'(res8), 256'(0));
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("rst_no_finish8", 256'(done8), 256'(9));
    go8(8'd7, 8'd5, 8'd11, 4'd3, 8'd10, 1'b0);    wait8(10, 200);

    // Full-width 256-bit run, exponent length 0 meaning all 256 bits
    begin
      exp_t e;
      int   budget;
      @(negedge clk);
      a256 = 256'd2; d256 = 256'd10; n256 = 256'd1000003; len256 = 9'd0; start256 = 1'b1;
      e.res = 256'd1024; e.err = 1'b0; e.acc_cyc = cyc + 1;
      e.lat = lat_model(256, 0, 256'd10);
      q256.push_back(e);
      budget = e.lat + 50;
      @(negedge clk);
      start256 = 1'b0; a256 = '1; d256 = '0; n256 = '0; len256 = 9'd5;
      for (int i = 0; i < budget && done256 < 1; i++) begin
        @(negedge clk); #1;
      end
      if (done256 < 1) begin
        total++;
        $display("FAIL timeout256: actual=%0d required=1", done256);
      end
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
